// File: rtl/cpu_defs.sv
// Shared CPU definitions: serial-port addresses, status bit layout and the
// uart_ctrl FSM state encoding.
package cpu_defs;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  localparam int STAT_TX_READY = 0;
  localparam int STAT_RX_READY = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ST_RD    = 4'd1,
    RD_WAIT  = 4'd2,
    RD_PULSE = 4'd3,
    RD_END   = 4'd4,
    WR_WAIT  = 4'd5,
    WR_SETUP = 4'd6,
    WR_PULSE = 4'd7,
    WR_HOLD  = 4'd8,
    DONE     = 4'd9
  } uart_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, one chain per bit.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end
      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_ctrl.sv
// Memory-side controller for the external UART sharing the ram1 data bus:
// sequences rdn/wrn strobes, owns the bus during the access and stalls the pipe.
module uart_ctrl
  import cpu_defs::*;
#(
  parameter int          RD_PULSE_CYCLES = 2,
  parameter int          WR_PULSE_CYCLES = 2,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'hFFFF
) (
  input  logic        uci_clk,
  input  logic        uci_rst,
  input  logic        uci_req,
  input  logic        uci_we,
  input  logic        uci_sel,
  input  logic [15:0] uci_wdata,
  output logic [15:0] uco_rdata,
  output logic        uco_done,
  output logic        uco_err,
  output logic        uco_pause_request,
  input  logic [15:0] uci_bus_in,
  output logic [15:0] uco_bus_out,
  output logic        uco_bus_oe,
  output logic        uco_ram1_disable,
  output logic        uco_rdn,
  output logic        uco_wrn,
  input  logic        uci_data_ready,
  input  logic        uci_tbre,
  input  logic        uci_tsre
);

  localparam logic [7:0]  RD_LAST = 8'(RD_PULSE_CYCLES - 1);
  localparam logic [7:0]  WR_LAST = 8'(WR_PULSE_CYCLES - 1);
  localparam logic [15:0] TO_LAST = TIMEOUT_CYCLES - 16'd1;

  logic [2:0] async_sync;
  logic       dr_s, tbre_s, tsre_s, tx_ready;

  sync2 #(.WIDTH(3)) u_sync (
    .clk  (uci_clk),
    .srst (uci_rst),
    .d    ({uci_tsre, uci_tbre, uci_data_ready}),
    .q    (async_sync)
  );

  assign dr_s     = async_sync[0];
  assign tbre_s   = async_sync[1];
  assign tsre_s   = async_sync[2];
  assign tx_ready = tbre_s & tsre_s;

  // Only the low byte of the bus and write data is meaningful to the UART.
  logic unused_bits;
  assign unused_bits = &{1'b0, uci_wdata[15:8], uci_bus_in[15:8]};

  uart_state_t state_reg, state_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic [7:0]  pulse_cnt_reg, pulse_cnt_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;
  logic        rdn_reg, wrn_reg, oe_reg;
  logic [15:0] bus_out_reg;
  logic        oe_next;

  always_comb begin
    state_next     = state_reg;
    to_cnt_next    = to_cnt_reg;
    pulse_cnt_next = pulse_cnt_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;
    case (state_reg)
      IDLE: begin
        if (uci_req) begin
          err_next       = 1'b0;
          to_cnt_next    = 16'd0;
          pulse_cnt_next = 8'd0;
          if (uci_sel) state_next = uci_we ? DONE : ST_RD;
          else         state_next = uci_we ? WR_WAIT : RD_WAIT;
        end
      end
      ST_RD: begin
        rdata_next                = 16'h0000;
        rdata_next[STAT_TX_READY] = tx_ready;
        rdata_next[STAT_RX_READY] = dr_s;
        state_next                = DONE;
      end
      RD_WAIT: begin
        if (!uci_req) begin
          state_next = IDLE;
        end else if (dr_s) begin
          pulse_cnt_next = 8'd0;
          state_next     = RD_PULSE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          rdata_next = 16'h0000;
          state_next = DONE;
        end else begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
      end
      RD_PULSE: begin
        if (pulse_cnt_reg == RD_LAST) begin
          rdata_next = {8'h00, uci_bus_in[7:0]};
          state_next = RD_END;
        end else begin
          pulse_cnt_next = pulse_cnt_reg + 8'd1;
        end
      end
      RD_END: state_next = DONE;
      WR_WAIT: begin
        if (!uci_req) begin
          state_next = IDLE;
        end else if (tx_ready) begin
          state_next = WR_SETUP;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          rdata_next = 16'h0000;
          state_next = DONE;
        end else begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
      end
      WR_SETUP: begin
        pulse_cnt_next = 8'd0;
        state_next     = WR_PULSE;
      end
      WR_PULSE: begin
        if (pulse_cnt_reg == WR_LAST) state_next = WR_HOLD;
        else                          pulse_cnt_next = pulse_cnt_reg + 8'd1;
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign oe_next = (state_next == WR_SETUP) || (state_next == WR_PULSE) ||
                   (state_next == WR_HOLD);

  // Strobes and bus enable are registered from the next state so they line
  // up exactly with the state they belong to and never glitch.
  always_ff @(posedge uci_clk) begin
    if (uci_rst) begin
      state_reg     <= IDLE;
      to_cnt_reg    <= 16'd0;
      pulse_cnt_reg <= 8'd0;
      rdata_reg     <= 16'h0000;
      err_reg       <= 1'b0;
      rdn_reg       <= 1'b1;
      wrn_reg       <= 1'b1;
      oe_reg        <= 1'b0;
      bus_out_reg   <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      to_cnt_reg    <= to_cnt_next;
      pulse_cnt_reg <= pulse_cnt_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      rdn_reg       <= (state_next != RD_PULSE);
      wrn_reg       <= (state_next != WR_PULSE);
      oe_reg        <= oe_next;
      if (state_reg == WR_WAIT && state_next == WR_SETUP)
        bus_out_reg <= {8'h00, uci_wdata[7:0]};
      else if (!oe_next)
        bus_out_reg <= 16'h0000;
    end
  end

  assign uco_rdata         = rdata_reg;
  assign uco_err           = err_reg;
  assign uco_done          = (state_reg == DONE);
  assign uco_rdn           = rdn_reg;
  assign uco_wrn           = wrn_reg;
  assign uco_bus_oe        = oe_reg;
  assign uco_bus_out       = bus_out_reg;
  assign uco_ram1_disable  = (state_reg != IDLE) && (state_reg != DONE);
  assign uco_pause_request = uci_req && (state_reg != DONE) && !uci_rst;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: status/data reads, writes, timeout, reset
// mid-strobe and back-to-back writes, checked against hand-derived values.
module tb_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, sel = 1'b0;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] bus_in = 16'h0000;
  logic        dr = 1'b0, tbre = 1'b0, tsre = 1'b0;
  logic [15:0] rdata, bus_out;
  logic        done, err, pause, oe, dis, rdn, wrn;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol_cnt = 0;

  logic        tr_rdn[64], tr_wrn[64], tr_oe[64], tr_dis[64], tr_pause[64], tr_done[64];
  logic [15:0] tr_bus[64];

  uart_ctrl #(.RD_PULSE_CYCLES(2), .WR_PULSE_CYCLES(2), .TIMEOUT_CYCLES(16'd16)) dut (
    .uci_clk(clk), .uci_rst(rst), .uci_req(req), .uci_we(we), .uci_sel(sel),
    .uci_wdata(wdata), .uco_rdata(rdata), .uco_done(done), .uco_err(err),
    .uco_pause_request(pause), .uci_bus_in(bus_in), .uco_bus_out(bus_out),
    .uco_bus_oe(oe), .uco_ram1_disable(dis), .uco_rdn(rdn), .uco_wrn(wrn),
    .uci_data_ready(dr), .uci_tbre(tbre), .uci_tsre(tsre)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rdn && !wrn) viol_cnt++;
    if (oe && !dis) viol_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic sample(input int i);
    tr_rdn[i] = rdn; tr_wrn[i] = wrn; tr_oe[i] = oe; tr_dis[i] = dis;
    tr_pause[i] = pause; tr_done[i] = done; tr_bus[i] = bus_out;
  endtask

  // Runs until done or max cycles; index k holds the state after k edges.
  task automatic run(input int max, output int cyc);
    cyc = 0;
    sample(0);
    while (cyc < max) begin
      @(negedge clk);
      cyc++;
      sample(cyc);
      if (done) break;
    end
  endtask

  function automatic int count_low_rdn(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (!tr_rdn[i]) c++;
    return c;
  endfunction

  function automatic int count_low_wrn(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (!tr_wrn[i]) c++;
    return c;
  endfunction

  initial begin
    int cyc, p, n_oe, n_dis, falls, dones, d1, d2;
    logic saw_done;

    dr = 1'b1; tbre = 1'b1; tsre = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state
    chk("rst_rdn", rdn, 1); chk("rst_wrn", wrn, 1); chk("rst_oe", oe, 0);
    chk("rst_bus_out", bus_out, 16'h0000); chk("rst_rdata", rdata, 16'h0000);
    chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_dis", dis, 0);
    chk("rst_pause", pause, 0);
    repeat (3) @(negedge clk);

    // status read
    req = 1; we = 0; sel = 1;
    run(10, cyc);
    $display("txn status_read cyc=%0d rdata=%h err=%b", cyc, rdata, err);
    chk("st_latency", cyc, 2);
    chk("st_rdata", rdata, 16'h0003);
    chk("st_err", err, 0);
    chk("st_no_strobe", count_low_rdn(cyc) + count_low_wrn(cyc), 0);
    req = 0;
    @(negedge clk);

    // data read, data_ready rising 5 cycles after req
    dr = 0; bus_in = 16'hAA5A;
    repeat (3) @(negedge clk);
    req = 1; we = 0; sel = 0;
    fork begin repeat (5) @(negedge clk); dr = 1; end join_none
    run(40, cyc);
    $display("txn data_read cyc=%0d rdata=%h err=%b", cyc, rdata, err);
    chk("rd_done_seen", tr_done[cyc], 1);
    chk("rd_rdn_low_cycles", count_low_rdn(cyc), 2);
    chk("rd_rdata", rdata, 16'h005A);
    chk("rd_err", err, 0);
    n_dis = 0;
    for (int i = 1; i < cyc; i++) if (tr_dis[i]) n_dis++;
    chk("rd_dis_throughout", n_dis, cyc - 1);
    chk("rd_dis_at_done", tr_dis[cyc], 0);
    chk("rd_pause_before_done", tr_pause[cyc-1], 1);
    chk("rd_pause_at_done", tr_pause[cyc], 0);
    chk("rd_no_wrn", count_low_wrn(cyc), 0);
    req = 0;
    @(negedge clk);

    // write with tsre low for 10 cycles
    tsre = 0; wdata = 16'h1234;
    repeat (3) @(negedge clk);
    req = 1; we = 1; sel = 0;
    fork begin repeat (10) @(negedge clk); tsre = 1; end join_none
    run(40, cyc);
    $display("txn write cyc=%0d", cyc);
    p = 1;
    for (int i = cyc; i >= 1; i--) if (!tr_wrn[i]) p = i;
    n_oe = 0;
    for (int i = 1; i <= cyc; i++) if (tr_oe[i]) n_oe++;
    chk("wr_done_seen", tr_done[cyc], 1);
    chk("wr_wrn_low_cycles", count_low_wrn(cyc), 2);
    chk("wr_no_wrn_before_ready", (p >= 12), 1);
    chk("wr_wrn_contiguous", tr_wrn[p+1], 0);
    chk("wr_oe_setup", tr_oe[p-1], 1);
    chk("wr_oe_hold", tr_oe[p+2], 1);
    chk("wr_oe_cycles", n_oe, 4);
    chk("wr_bus_setup", tr_bus[p-1], 16'h0034);
    chk("wr_bus_pulse", tr_bus[p], 16'h0034);
    chk("wr_bus_hold", tr_bus[p+2], 16'h0034);
    chk("wr_done_after_hold", cyc, p + 3);
    chk("wr_no_rdn", count_low_rdn(cyc), 0);
    req = 0;
    @(negedge clk);

    // read timeout
    dr = 0;
    repeat (3) @(negedge clk);
    req = 1; we = 0; sel = 0;
    run(40, cyc);
    $display("txn read_timeout cyc=%0d rdata=%h err=%b", cyc, rdata, err);
    chk("to_done_seen", tr_done[cyc], 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 16'h0000);
    chk("to_no_rdn", count_low_rdn(cyc), 0);
    chk("to_latency_window", (cyc >= 16 && cyc <= 18), 1);
    req = 0;
    @(negedge clk);

    // reset asserted during RD_PULSE
    dr = 1;
    repeat (3) @(negedge clk);
    req = 1; we = 0; sel = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rdn) break;
    end
    chk("rstm_reached_pulse", rdn, 0);
    rst = 1;
    @(negedge clk);
    $display("txn reset_mid_read rdn=%b done=%b rdata=%h", rdn, done, rdata);
    chk("rstm_rdn", rdn, 1); chk("rstm_wrn", wrn, 1); chk("rstm_oe", oe, 0);
    chk("rstm_bus_out", bus_out, 16'h0000); chk("rstm_rdata", rdata, 16'h0000);
    chk("rstm_done", done, 0); chk("rstm_err", err, 0); chk("rstm_pause", pause, 0);
    rst = 0; req = 0;
    saw_done = 0;
    repeat (6) begin @(negedge clk); if (done) saw_done = 1; end
    chk("rstm_no_done", saw_done, 0);

    // back-to-back writes with req held
    req = 1; we = 1; sel = 0; wdata = 16'h1234;
    sample(0);
    for (int i = 1; i <= 14; i++) begin @(negedge clk); sample(i); end
    req = 0;
    falls = 0; dones = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 14; i++) begin
      if (!tr_wrn[i] && tr_wrn[i-1]) falls++;
      if (tr_done[i]) begin
        dones++;
        if (d1 == 0) d1 = i; else d2 = i;
      end
    end
    $display("txn back_to_back falls=%0d dones=%0d d1=%0d d2=%0d", falls, dones, d1, d2);
    chk("b2b_wrn_pulses", falls, 2);
    chk("b2b_wrn_low_cycles", count_low_wrn(14), 4);
    chk("b2b_done_count", dones, 2);
    chk("b2b_done_spacing", d2 - d1, 7);
    chk("b2b_idle_after_done", tr_dis[d1+1], 0);
    repeat (4) @(negedge clk);

    chk("no_strobe_or_oe_overlap", viol_cnt, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
